div: RTL
========

# div

Multi-cycle 32-bit radix-2 restoring divider for the EX stage. It is the requester side of the pipeline stall protocol: `stallreq_o` drives the stall controller's `stallreq_from_ex` input while a division is in flight. The pipeline is frozen through EX until the result is ready. The 64-bit result `{remainder, quotient}` is delivered to EX with a one-cycle `ready_o` pulse.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high (`RstEnable` = 1'b1).
- `start_i` in 1: EX holds a divide instruction; held high until EX advances.
- `annul_i` in 1: cancel the current division; branch flush or exception.
- `signed_div_i` in 1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i` in 32: dividend; sampled only in DivFree.
- `opdata2_i` in 32: divisor; sampled only in DivFree.
- `result_o` out 64: {remainder[63:32], quotient[31:0]}; registered.
- `ready_o` out 1: result valid; registered one-cycle pulse.
- `stallreq_o` out 1: combinational stall request to the controller.

## Operation
- States:
  - DivFree (reset state).
  - DivByZero.
  - DivOn.
  - DivEnd.
- DivFree:
  - If `start_i` and !`annul_i` and divisor == 0, go to DivByZero.
  - If `start_i` and !`annul_i` and divisor != 0, latch operands, clear `cnt`, go to DivOn.
  - Otherwise stay in DivFree.
- Operand conditioning (signed): when `signed_div_i` = 1, negative operands are converted to two's-complement magnitudes. Sign flags are latched: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- DivByZero: `result_o` <= 0; go to DivEnd.
- DivOn, with `annul_i` = 1: go to DivFree; `ready_o` stays 0 and `result_o` is unchanged.
- DivOn, with `cnt` < 32: one restoring step per cycle on a 65-bit working register {rem, dividend}:
  - Compute a 33-bit trial = rem[32:0] − {1'b0, divisor}.
  - If trial is non-negative: shift {trial[31:0], dividend, 1'b1} into the working register.
  - Else: shift {working register << 1} with 0 into the LSB.
  - `cnt` increments.
- DivOn, with `cnt` == 32: apply sign correction, write `result_o`, go to DivEnd.
- DivEnd: `ready_o` = 1 for exactly this cycle; unconditionally go to DivFree next edge. `start_i` is ignored in DivEnd.
- `stallreq_o` = `start_i` & !`annul_i` & (state != DivEnd). It is high from the first cycle of the request until the ready cycle.
- Signed overflow 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. No trap.
- `result_o` holds its last value until the next completion.

## Timing
- Cycle 0 is the first cycle in which `start_i` = 1 is seen in DivFree.
- Normal divide: DivOn covers cycles 1..33 (32 iterations, then the finalize step).
  - `ready_o` and the valid `result_o` appear in cycle 34.
  - `stallreq_o` is high in cycles 0..33 and low in cycle 34.
- Divide by zero: DivByZero in cycle 1; `ready_o` in cycle 2; `stallreq_o` high in cycles 0..1.
- Back-to-back divides: DivFree is reached in cycle 35. A new `start_i` in cycle 35 begins the next divide, so there is one idle cycle between divides.
- `annul_i` in cycle k of DivOn: DivFree in cycle k+1; `stallreq_o` is low in cycle k.
- Reset values: state DivFree, `cnt` 0, `ready_o` 0, `result_o` 0. `stallreq_o` follows its inputs combinationally.
- `rst` asserted mid-operation aborts the division in the next cycle. No `ready_o` is produced.

## Configuration
- `DIV_SIGNED_EN` defined: signed path compiled in; `signed_div_i` honoured.
- `DIV_SIGNED_EN` undefined:
  - Negation and sign-correction logic is removed.
  - `signed_div_i` is ignored, and all operations are unsigned.
  - Latency is unchanged.

## Test plan
- Unsigned divide, 100 / 7:
  - `ready_o` in cycle 34 with `result_o` = {32'd2, 32'd14}.
  - `stallreq_o` high in cycles 0–33.
- Signed divide, 0xFFFFFFF9 / 2 (with `DIV_SIGNED_EN`):
  - `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}.
  - Same stimulus without the macro: `result_o` = {0x00000001, 0x7FFFFFFC}.
- Divide by zero, 5 / 0:
  - `ready_o` in cycle 2 with `result_o` = 0.
  - `stallreq_o` high in cycles 0–1 only.
- Annul: `annul_i` pulsed in cycle 10 → state DivFree in cycle 11; no `ready_o`; `result_o` keeps its previous value.
- Back-to-back: 100/7, then 0x80000000/0xFFFFFFFF signed, with `start_i` reasserted in cycle 35.
  - Second `ready_o` in cycle 69 with `result_o` = {0, 0x80000000}.
- Reset: `rst` in cycle 20 → `ready_o`, `result_o` and `cnt` are all 0 in cycle 21; state DivFree.

Source files
------------

// File: rtl/div_if.sv
// EX-stage <-> divider handshake bundle: request, operands, result and stall request.
// The master modport is the EX stage; the slave modport is the divider.
interface div_if;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider; stalls the pipeline while busy.
// Define DIV_SIGNED_EN to compile in signed (DIV) support; otherwise every operation is DIVU.
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_t;

    div_state_t  state_r;
    logic [5:0]  cnt_r;
    logic [64:0] work_r;
    logic [31:0] divisor_r;
    logic [63:0] result_r;
    logic        ready_r;

    logic [31:0] op1_abs_s;
    logic [31:0] op2_abs_s;
    logic [32:0] trial_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    function automatic logic [31:0] negate32(input logic [31:0] val);
        return (~val) + 32'd1;
    endfunction

`ifdef DIV_SIGNED_EN
    logic        neg_quot_r;
    logic        neg_rem_r;
    logic        neg_quot_s;
    logic        neg_rem_s;

    // Operand magnitudes and result sign flags for the signed path
    always_comb begin
        neg_quot_s = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
        neg_rem_s  = bus.signed_div_i & bus.opdata1_i[31];
        if (bus.signed_div_i && bus.opdata1_i[31]) begin
            op1_abs_s = negate32(bus.opdata1_i);
        end else begin
            op1_abs_s = bus.opdata1_i;
        end
        if (bus.signed_div_i && bus.opdata2_i[31]) begin
            op2_abs_s = negate32(bus.opdata2_i);
        end else begin
            op2_abs_s = bus.opdata2_i;
        end
    end

    // Sign correction of the finished magnitudes
    always_comb begin
        if (neg_quot_r) begin
            quot_s = negate32(work_r[31:0]);
        end else begin
            quot_s = work_r[31:0];
        end
        if (neg_rem_r) begin
            rem_s = negate32(work_r[64:33]);
        end else begin
            rem_s = work_r[64:33];
        end
    end
`else
    logic unused_signed_s;

    assign unused_signed_s = bus.signed_div_i;

    // Unsigned-only build: operands and results pass straight through
    always_comb begin
        op1_abs_s = bus.opdata1_i;
        op2_abs_s = bus.opdata2_i;
        quot_s    = work_r[31:0];
        rem_s     = work_r[64:33];
    end
`endif

    // Trial subtraction of the divisor from the partial remainder
    always_comb begin
        trial_s = {1'b0, work_r[63:32]} - {1'b0, divisor_r};
    end

    // Divider FSM: operand capture, one restoring step per cycle, result finalize
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DIV_FREE;
            cnt_r      <= 6'd0;
            work_r     <= 65'd0;
            divisor_r  <= 32'd0;
            result_r   <= 64'd0;
            ready_r    <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                DIV_FREE: begin
                    ready_r <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == 32'd0) begin
                            state_r <= DIV_BY_ZERO;
                        end else begin
                            state_r    <= DIV_ON;
                            cnt_r      <= 6'd0;
                            // Dividend MSB already sits in the trial window for step 0
                            work_r     <= {32'd0, op1_abs_s, 1'b0};
                            divisor_r  <= op2_abs_s;
`ifdef DIV_SIGNED_EN
                            neg_quot_r <= neg_quot_s;
                            neg_rem_r  <= neg_rem_s;
`endif
                        end
                    end else begin
                        state_r <= DIV_FREE;
                    end
                end
                DIV_BY_ZERO: begin
                    result_r <= 64'd0;
                    ready_r  <= 1'b1;
                    state_r  <= DIV_END;
                end
                DIV_ON: begin
                    if (bus.annul_i) begin
                        state_r <= DIV_FREE;
                        ready_r <= 1'b0;
                    end else if (cnt_r != 6'd32) begin
                        if (trial_s[32]) begin
                            work_r <= {work_r[63:0], 1'b0};
                        end else begin
                            work_r <= {trial_s[31:0], work_r[31:0], 1'b1};
                        end
                        cnt_r <= cnt_r + 6'd1;
                    end else begin
                        result_r <= {rem_s, quot_s};
                        ready_r  <= 1'b1;
                        state_r  <= DIV_END;
                    end
                end
                DIV_END: begin
                    ready_r <= 1'b0;
                    state_r <= DIV_FREE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= DIV_FREE;
                end
            endcase
        end
    end

    assign bus.result_o   = result_r;
    assign bus.ready_o    = ready_r;
    assign bus.stallreq_o = bus.start_i & ~bus.annul_i & (state_r != DIV_END);

endmodule
